simple_if_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream simple-interface channel (data + valid) between NUM_REQ upstream requesters.
- Requesters are typically the elements of an interface array driven from a generate loop.
- The block uses a valid/ready handshake on every port and has a single registered output stage.
- It sits between the per-instance interface array and the one consumer.

---
 rtl/simple_if_rr_arbiter_if.sv | 27 ++
 rtl/simple_if_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_simple_if_rr_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/simple_if_rr_arbiter_if.sv
// Bundle of the requester-side and consumer-side signals of simple_if_rr_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface simple_if_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 1
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_ready;
    logic [IdW-1:0]            grant_id;
    logic                      busy;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, grant_id, busy
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, grant_id, busy
    );
endinterface

// File: rtl/simple_if_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready requesters into one registered output.
// Define ARB_BURST_EN to let the previous winner keep the grant for up to MAX_BURST words.
module simple_if_rr_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned DATA_W    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    simple_if_rr_arbiter_if.slave bus
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StActive, StStall} state_e;

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [IdW-1:0]      grant_id_q, grant_id_d;
    logic [IdW-1:0]      last_q, last_d;
`ifdef ARB_BURST_EN
    logic [7:0]          burst_q, burst_d;
`endif

    logic                slot_free;
    logic                found;
    logic                accept;
    logic [IdW-1:0]      win;
    logic [IdW-1:0]      idx;
    logic [NUM_REQ-1:0]  req_ready;

    assign slot_free = !out_valid_q || bus.out_ready;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
`ifdef ARB_BURST_EN
        if (burst_q != 8'd0 && 32'(burst_q) < MAX_BURST && bus.req_valid[last_q]) begin
            found = 1'b1;
            win   = last_q;
        end
`endif
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IdW'((32'(last_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Gating with rst_n keeps the upstream from losing a word to a reset edge.
    assign accept = rst_n && slot_free && found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        grant_id_d  = grant_id_q;
        last_d      = last_q;
        state_d     = state_q;
`ifdef ARB_BURST_EN
        burst_d     = burst_q;
`endif

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.req_data[32'(win)*DATA_W +: DATA_W];
            grant_id_d  = win;
            last_d      = win;
`ifdef ARB_BURST_EN
            if (win == last_q && burst_q != 8'd0 && 32'(burst_q) < MAX_BURST) begin
                burst_d = burst_q + 8'd1;
            end else begin
                burst_d = 8'd1;
            end
`endif
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StActive;
                end
            end
            StActive, StStall: begin
                if (accept) begin
                    state_d = StActive;
                end else if (bus.out_ready) begin
                    state_d = StIdle;
                end else begin
                    state_d = StStall;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef ARB_BURST_EN
        if (state_d == StIdle) begin
            burst_d = 8'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            grant_id_q  <= '0;
            last_q      <= IdW'(NUM_REQ - 1);
`ifdef ARB_BURST_EN
            burst_q     <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            grant_id_q  <= grant_id_d;
            last_q      <= last_d;
`ifdef ARB_BURST_EN
            burst_q     <= burst_d;
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_simple_if_rr_arbiter.sv
// Table-driven bench for simple_if_rr_arbiter with a scoreboard of accepted words.
// Honours ARB_BURST_EN so the same bench checks both builds.
module tb_simple_if_rr_arbiter;
    localparam int unsigned NumReq = 2;
    localparam int unsigned DataW  = 8;
`ifdef ARB_BURST_EN
    localparam bit BurstEn = 1'b1;
`else
    localparam bit BurstEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    simple_if_rr_arbiter_if #(.NUM_REQ(NumReq), .DATA_W(DataW)) bus ();

    simple_if_rr_arbiter #(
        .NUM_REQ  (NumReq),
        .DATA_W   (DataW),
        .MAX_BURST(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [15:0] data;
        logic        ordy;
        logic [1:0]  exp_ready;
        logic        exp_ov;
        logic        exp_zero;
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] data;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each row gets distinct data so a word sampled on the wrong edge is caught.
    function automatic void add(input logic rst, input logic [1:0] valid, input logic ordy,
                                input logic [1:0] exp_ready, input logic exp_ov,
                                input logic exp_zero);
        vec_t v;
        int   n;
        n           = tbl.size();
        v.rst       = rst;
        v.valid     = valid;
        v.data      = {8'h40 + 8'(n), 8'hC0 + 8'(n)};
        v.ordy      = ordy;
        v.exp_ready = exp_ready;
        v.exp_ov    = exp_ov;
        v.exp_zero  = exp_zero;
        tbl.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n         = v.rst;
        bus.req_valid = v.valid;
        bus.req_data  = v.data;
        bus.out_ready = v.ordy;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(v.exp_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(v.exp_ov));
        chk("busy", 32'(bus.busy), 32'(v.exp_ov));
        if (v.exp_zero) begin
            chk("rst_out_data", 32'(bus.out_data), 32'd0);
            chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        end
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: actual=out_valid with no word required=empty at %0t",
                         $time);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(sb[0].data));
                chk("grant_id", 32'(bus.grant_id), 32'(sb[0].id));
                if (v.ordy && v.rst) begin
                    void'(sb.pop_front());
                end
            end
        end
        if (!v.rst) begin
            sb.delete();
        end
        if (v.exp_ready != 2'b00) begin
            e.id   = v.exp_ready[1];
            e.data = e.id ? v.data[15:8] : v.data[7:0];
            sb.push_back(e);
        end
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end
        tbl.delete();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk);

        // Reset held with every requester asking.
        for (int i = 0; i < 3; i++) add(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1);
        run_tbl();

        // Both valid, consumer always ready: alternation, or 4-word bursts.
        for (int i = 0; i < 9; i++) begin
            logic id;
            id = BurstEn ? 1'((i / 4) % 2) : 1'(i % 2);
            add(1'b1, 2'b11, 1'b1, id ? 2'b10 : 2'b01, i != 0, 1'b0);
        end
        add(1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
        add(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
        run_tbl();

        // Backpressure: hold for 4 cycles, then release accepts in the same cycle.
        add(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0);
        add(1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) add(1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0);
        add(1'b1, 2'b11, 1'b1, BurstEn ? 2'b01 : 2'b10, 1'b1, 1'b0);
        add(1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
        add(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
        run_tbl();

        // Single requester streaming, then drain to idle.
        add(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b1, 2'b10, 1'b1, 2'b10, i != 0, i == 0);
        add(1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
        add(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
        run_tbl();

        // Reset during a stall discards the word and restores requester 0 priority.
        add(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0);
        add(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1);
        add(1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0);
        add(1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0);
        add(1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1);
        add(1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
        add(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
        run_tbl();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
